gen_chain_multi: RTL

Parametrised WOTS chain engine: the successor to the single-chain walker. It walks all WOTS_LEN chains of one WOTS key sequentially in one of three modes: key generation, signing, or verification. Per-chain inputs arrive on a ready/valid stream and chain results leave on one. Each chain step is issued to an external thash_f-style hash engine over a start/done handshake. It sits between the WOTS top-level controller and the shared thash_f/SHA-256 datapath.

---
 rtl/gen_chain_multi.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gen_chain_multi.sv
// WOTS chain engine: walks every chain of one key through an external F engine
// (keygen, sign or verify), keeping at most one hash outstanding.
module gen_chain_multi #(
    parameter int WOTS_W     = 16,
    parameter int WOTS_LOG_W = $clog2(WOTS_W),
    parameter int WOTS_LEN   = 67,
    parameter int KEY_LEN    = 256,
    parameter int IDX_W      = $clog2(WOTS_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [255:0]          hash_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [KEY_LEN-1:0]    in_data,
    input  logic [WOTS_LOG_W-1:0] in_digit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [KEY_LEN-1:0]    out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  busy,
    output logic                  done,
    output logic                  f_start,
    output logic [KEY_LEN-1:0]    f_din,
    output logic [255:0]          f_addr,
    input  logic                  f_done,
    input  logic [KEY_LEN-1:0]    f_dout
);
    // One extra step bit so step+1 never wraps back to zero at W-1.
    localparam int SW = WOTS_LOG_W + 1;
    localparam logic [SW-1:0]    LAST_STEP   = SW'(WOTS_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WOTS_LEN - 1);
    localparam logic [1:0]       MODE_KEYGEN = 2'd0;
    localparam logic [1:0]       MODE_SIGN   = 2'd1;
    localparam logic [1:0]       MODE_RSVD   = 2'd3;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT} state_t;

    state_t             state, state_next;
    logic [1:0]         mode_q;
    logic [159:0]       base_hi;
    logic [31:0]        base_lo;
    logic [IDX_W-1:0]   idx;
    logic [SW-1:0]      step, end_step;
    logic [KEY_LEN-1:0] cur;
    logic               done_q;

    logic [SW-1:0] digit_ext, first_step, last_step, step_inc;
    logic          start_ok;

    // The chain and step words of the base address are replaced per hash.
    logic unused_addr_bits;
    assign unused_addr_bits = ^hash_addr[95:32];

    assign digit_ext = SW'(in_digit);
    assign step_inc  = step + SW'(1);
    assign start_ok  = start && (mode != MODE_RSVD);

    always_comb begin
        first_step = '0;
        last_step  = LAST_STEP;
        case (mode_q)
            MODE_KEYGEN: ;
            MODE_SIGN:   last_step  = digit_ext;
            default:     first_step = digit_ext;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        f_start    = 1'b0;
        case (state)
            IDLE:  if (start_ok) state_next = FETCH;
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (first_step == last_step) ? EMIT : ISSUE;
            end
            ISSUE: begin
                f_start    = 1'b1;
                state_next = WAIT;
            end
            WAIT:  if (f_done) state_next = (step_inc == end_step) ? EMIT : ISSUE;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = (idx == LAST_IDX) ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= '0;
            base_hi  <= '0;
            base_lo  <= '0;
            idx      <= '0;
            step     <= '0;
            end_step <= '0;
            cur      <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (start_ok) begin
                    mode_q  <= mode;
                    base_hi <= hash_addr[255:96];
                    base_lo <= hash_addr[31:0];
                    idx     <= '0;
                end
                FETCH: if (in_valid) begin
                    cur      <= in_data;
                    step     <= first_step;
                    end_step <= last_step;
                end
                WAIT: if (f_done) begin
                    cur  <= f_dout;
                    step <= step_inc;
                end
                EMIT: if (out_ready) begin
                    if (idx == LAST_IDX) done_q <= 1'b1;
                    else                 idx    <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // done is registered, so busy must also cover the IDLE cycle that carries it.
    assign busy      = (state != IDLE) || done_q;
    assign done      = done_q;
    assign out_data  = cur;
    assign out_index = idx;
    assign f_din     = cur;
    assign f_addr    = {base_hi, 32'(idx), 32'(step), base_lo};

endmodule
